// File: rtl/memory_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter
//  Description : Shares a single-ported unified RAM between instruction fetch
//                and the load/store path. Data requests win arbitration unless
//                a pending fetch has been passed over STARVE_LIMIT times in a
//                row. Each access is bounded by a wait counter. If the counter
//                expires, the access is aborted and a sticky bus_err is raised,
//                so the pipeline does not deadlock.
//  Ports       : CLK, nRST           - clock, async active-low reset
//                iren/iaddr          - fetch request (held until ihit)
//                iload/ihit          - fetch data / completion strobe
//                dren/dwen/daddr/
//                dstore              - data request (held until dhit)
//                dload/dhit          - load data / completion strobe
//                ram_ren/ram_wen/
//                ram_addr/ram_store  - RAM command (combinational from state)
//                ram_load/ram_ready  - RAM response
//                bus_err             - sticky access-timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iren,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              ihit,
    input  logic              dren,
    input  logic              dwen,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dhit,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready,
    output logic              bus_err
);

    localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
    // The counter only ever holds 0..TIMEOUT-1; abort fires as it would reach TIMEOUT.
    localparam int c_wait_w   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);
    localparam logic [c_wait_w-1:0]   c_wait_last  = c_wait_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IACC = 2'd1,
        S_DACC = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_starve_w-1:0] r_starve;
    logic [c_wait_w-1:0]   r_wait;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_store;
    logic                r_write;
    logic                r_bus_err;

    logic w_dreq;
    logic w_force_fetch;

    assign w_dreq        = dren | dwen;
    assign w_force_fetch = iren && (r_starve == c_starve_max);
    assign bus_err       = r_bus_err;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= S_IDLE;
            r_starve  <= '0;
            r_wait    <= '0;
            r_addr    <= '0;
            r_store   <= '0;
            r_write   <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wait <= '0;
                    if (w_dreq && !w_force_fetch) begin
                        r_state <= S_DACC;
                        r_addr  <= daddr;
                        r_store <= dstore;
                        // dren and dwen together resolve to a write.
                        r_write <= dwen;
                        if (iren) begin
                            if (r_starve != c_starve_max) begin
                                r_starve <= r_starve + 1'b1;
                            end
                        end else begin
                            r_starve <= '0;
                        end
                    end else if (iren) begin
                        r_state  <= S_IACC;
                        r_addr   <= iaddr;
                        r_starve <= '0;
                    end else begin
                        r_starve <= '0;
                    end
                end
                S_IACC, S_DACC: begin
                    if (ram_ready) begin
                        r_state <= S_IDLE;
                    end else if (r_wait == c_wait_last) begin
                        r_state   <= S_IDLE;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM command and completion strobes follow the state directly so that
    // an asynchronous reset drops the enables immediately and a hit lands in
    // the same cycle as ram_ready. Hits are gated by the live request so a
    // requester that let go mid-access sees nothing.
    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        ihit      = 1'b0;
        dhit      = 1'b0;
        iload     = '0;
        dload     = '0;
        case (r_state)
            S_IACC: begin
                ram_ren  = 1'b1;
                ram_addr = r_addr;
                if (ram_ready) begin
                    ihit  = iren;
                    iload = ram_load;
                end
            end
            S_DACC: begin
                ram_ren   = !r_write;
                ram_wen   = r_write;
                ram_addr  = r_addr;
                ram_store = r_store;
                if (ram_ready) begin
                    dhit  = w_dreq;
                    dload = r_write ? '0 : ram_load;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_memory_arbiter
//  Description : Self-checking bench for memory_arbiter. A small RAM model
//                with programmable latency answers the arbiter; expected
//                completions are queued per requester when a request is
//                driven and popped when the matching hit appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int c_aw = 32;
    localparam int c_dw = 32;

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic            iren = 1'b0;
    logic [c_aw-1:0] iaddr = '0;
    logic [c_dw-1:0] iload;
    logic            ihit;
    logic            dren = 1'b0;
    logic            dwen = 1'b0;
    logic [c_aw-1:0] daddr = '0;
    logic [c_dw-1:0] dstore = '0;
    logic [c_dw-1:0] dload;
    logic            dhit;
    logic            ram_ren;
    logic            ram_wen;
    logic [c_aw-1:0] ram_addr;
    logic [c_dw-1:0] ram_store;
    logic [c_dw-1:0] ram_load;
    logic            ram_ready;
    logic            bus_err;

    memory_arbiter #(
        .ADDR_W(c_aw), .DATA_W(c_dw), .STARVE_LIMIT(4), .TIMEOUT(255)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .iren(iren), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
        .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- RAM model ----------------
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
    endfunction

    logic [31:0] ram [0:1023];
    bit          written [0:1023];
    int          lat = 0;
    int          cnt = 0;

    assign ram_ready = (ram_ren | ram_wen) && (cnt >= lat);
    assign ram_load  = (ram_ren && ram_ready) ?
                       (written[ram_addr[9:0]] ? ram[ram_addr[9:0]] : dflt(ram_addr)) : '0;

    always @(posedge CLK) begin
        if (ram_wen && ram_ready) begin
            ram[ram_addr[9:0]]     <= ram_store;
            written[ram_addr[9:0]] <= 1'b1;
        end
        cnt <= ((ram_ren | ram_wen) && !ram_ready) ? cnt + 1 : 0;
    end

    // ---------------- expected-memory model and scoreboard ----------------
    logic [31:0] shadow [0:1023];
    bit          s_written [0:1023];

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return s_written[a[9:0]] ? shadow[a[9:0]] : dflt(a);
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] sd;
        logic        wr;
    } txn_t;

    txn_t iq[$];
    txn_t dq[$];
    bit   glog[$];   // 1 = data grant completed, 0 = fetch grant completed
    logic prev_done = 1'b0;

    always @(negedge CLK) begin : mon
        txn_t t;
        if (nRST) begin
            if (prev_done) chk("idle_gap", {63'b0, ram_ren | ram_wen}, 64'd0);
            if (ihit) begin
                if (iq.size() == 0) chk("ihit_unexpected", 1, 0);
                else begin
                    t = iq.pop_front();
                    chk("i_addr", ram_addr, t.addr);
                    chk("iload", iload, t.data);
                    glog.push_back(1'b0);
                end
            end
            if (dhit) begin
                if (dq.size() == 0) chk("dhit_unexpected", 1, 0);
                else begin
                    t = dq.pop_front();
                    chk("d_addr", ram_addr, t.addr);
                    chk("d_wen", ram_wen, t.wr);
                    chk("dload", dload, t.data);
                    if (t.wr) chk("d_store", ram_store, t.sd);
                    glog.push_back(1'b1);
                end
            end
            prev_done <= (ram_ren | ram_wen) && ram_ready;
        end else begin
            prev_done <= 1'b0;
        end
    end

    // ---------------- requester tasks ----------------
    task automatic wait_hit(input bit is_d, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 600 && !ok; k++) begin
            @(negedge CLK);
            if (is_d ? dhit : ihit) ok = 1'b1;
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        txn_t t;
        bit   ok;
        t.addr = a; t.data = exp_rd(a); t.sd = '0; t.wr = 1'b0;
        iaddr = a; iren = 1'b1;
        iq.push_back(t);
        wait_hit(1'b0, ok);
        chk("fetch_done", ok, 1);
        @(posedge CLK); #1;
        iren = 1'b0;
    endtask

    task automatic data_acc(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr);
        txn_t t;
        bit   ok;
        t.addr = a; t.wr = wr; t.sd = d;
        t.data = wr ? 32'h0 : exp_rd(a);
        if (wr) begin
            shadow[a[9:0]]    = d;
            s_written[a[9:0]] = 1'b1;
        end
        daddr = a; dstore = d; dren = rd; dwen = wr;
        dq.push_back(t);
        wait_hit(1'b1, ok);
        chk("data_done", ok, 1);
        @(posedge CLK); #1;
        dren = 1'b0; dwen = 1'b0;
    endtask

    task automatic chk_order(input string tag, input logic [7:0] expv, input int n);
        chk({tag, "_len"}, glog.size(), n);
        for (int k = 0; k < n && k < glog.size(); k++) chk(tag, glog[k], expv[n-1-k]);
        glog.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        // ---- reset state ----
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ram_cmd", {ram_ren, ram_wen, ram_addr, ram_store}, 0);
        chk("rst_hits", {ihit, dhit, bus_err}, 0);
        chk("rst_loads", {iload, dload}, 0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // ---- 1: single fetch, ready two cycles after access start ----
        lat = 2;
        begin
            txn_t t;
            t.addr = 32'h100; t.data = 32'hDEADBEEF; t.sd = '0; t.wr = 1'b0;
            iq.push_back(t);
        end
        iaddr = 32'h100; iren = 1'b1;
        @(negedge CLK);
        chk("t1_idle_first", ram_ren, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("t1_ren", ram_ren, 1);
            chk("t1_addr", ram_addr, 32'h100);
            chk("t1_ihit", ihit, (k == 2));
        end
        @(posedge CLK); #1;
        iren = 1'b0;
        @(negedge CLK);
        chk("t1_back_idle", ram_ren, 0);
        glog.delete();

        // ---- 2: contention, data write wins, then fetch ----
        lat = 0;
        fork
            fetch(32'h300);
            data_acc(32'h200, 32'h55, 1'b0, 1'b1);
        join
        chk_order("t2_order", 8'b10, 2);
        data_acc(32'h200, 32'h0, 1'b1, 1'b0);        // read-back of the store
        data_acc(32'h204, 32'h77, 1'b1, 1'b1);       // dren+dwen acts as write
        data_acc(32'h204, 32'h0, 1'b1, 1'b0);
        glog.delete();

        // ---- 3: starvation guard ----
        fork
            fetch(32'h40);
            begin
                for (int k = 0; k < 6; k++) data_acc(32'h80 + 32'(4 * k), 32'h0, 1'b1, 1'b0);
            end
        join
        chk_order("t3_order", 8'b1111011, 7);

        // ---- ready on the very last allowed cycle completes cleanly ----
        lat = 254;
        data_acc(32'h10, 32'h0, 1'b1, 1'b0);
        chk("late_ready_no_err", bus_err, 0);
        glog.delete();

        // ---- 5a: requester drops mid-access ----
        lat = 3;
        daddr = 32'h20; dren = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (ram_ren) begin
                n++;
                if (n == 2) dren = 1'b0;
            end else if (n > 0) break;
        end
        chk("drop_len", n, 4);
        chk("drop_idle", {ram_ren, ram_wen}, 0);

        // ---- 4: timeout ----
        lat = 100000;
        @(posedge CLK); #1;
        daddr = 32'h24; dren = 1'b1;
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge CLK);
            if (ram_ren) begin
                n++;
                if (n == 255) chk("to_no_err_yet", bus_err, 0);
            end else if (n > 0) break;
        end
        dren = 1'b0;
        chk("to_len", n, 255);
        chk("to_bus_err", bus_err, 1);
        lat = 0;
        @(posedge CLK); #1;
        fetch(32'h48);
        chk("to_err_sticky", bus_err, 1);

        // ---- 5b: reset in the middle of a fetch ----
        lat = 5;
        iaddr = 32'h44; iren = 1'b1;
        n = 0;
        for (int k = 0; k < 10 && n == 0; k++) begin
            @(negedge CLK);
            if (ram_ren) n = 1;
        end
        chk("rst_mid_started", n, 1);
        #2;
        nRST = 1'b0;
        #1;
        chk("rst_mid_ren", ram_ren, 0);
        chk("rst_mid_cmd", {ram_wen, ram_addr, ram_store}, 0);
        chk("rst_mid_out", {ihit, dhit, iload, dload, bus_err}, 0);
        iren = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        lat = 0;
        fetch(32'h100);

        chk("iq_empty", iq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single-ported unified RAM between instruction fetch and the data (load/store) path.
- Produces the ihit/dhit strobes that the hazard unit consumes for pipeline stall/enable decisions.
- Data requests have fixed priority, with a starvation guard for fetch.
- A per-access timeout flags a hung RAM and recovers the arbiter instead of deadlocking the pipeline.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending before fetch is forced
- TIMEOUT, 255, max cycles in an access state without ram_ready before abort

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- iren  in  1  fetch read request (held until ihit)
- iaddr  in  ADDR_W  fetch address
- iload  out  DATA_W  fetch data, valid when ihit
- ihit  out  1  fetch complete strobe
- dren  in  1  data read request (held until dhit)
- dwen  in  1  data write request (held until dhit)
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  store data
- dload  out  DATA_W  load data, valid when dhit
- dhit  out  1  data complete strobe
- ram_ren  out  1  RAM read enable
- ram_wen  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_store  out  DATA_W  RAM write data
- ram_load  in  DATA_W  RAM read data
- ram_ready  in  1  RAM access done this cycle
- bus_err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, CLK; reset nRST is asynchronous, active-low.
- Reset values:
  - State = IDLE.
  - Starve counter, wait counter, latched addr/store/type = 0.
  - bus_err = 0.
  - All RAM outputs = 0; ihit = dhit = 0; iload = dload = 0.
- States: IDLE, IACC, DACC.
- IDLE arbitration, evaluated each cycle:
  - If (dren|dwen) and not (iren and starve==STARVE_LIMIT): go to DACC. Latch daddr, dstore, and type (write if dwen, else read). If iren is also pending, starve increments (saturates at STARVE_LIMIT).
  - Otherwise, if iren: go to IACC. Latch iaddr. Clear starve to 0.
  - Otherwise: stay in IDLE.
- Starve clears whenever iren is low in IDLE.
- RAM outputs in IDLE are 0. RAM outputs are driven combinationally from state plus latched registers:
  - IACC: ram_ren=1, ram_addr=latched addr.
  - DACC: ram_ren=latched read, ram_wen=latched write, ram_addr and ram_store from latches.
- Completion:
  - IACC with ram_ready: ihit=iren, iload=ram_load, next state IDLE.
  - DACC with ram_ready: dhit=(dren|dwen), dload=ram_load (reads; 0 on writes), next state IDLE.
  - Hits are combinational, in the same cycle as ram_ready.
- Latency: request visible in IDLE at cycle N, RAM access asserted at N+1, earliest hit at N+1.
- Back-to-back: one mandatory IDLE cycle between accesses (RAM enables low).
- Requester drop mid-access: the RAM access still completes. No hit is issued because hits are gated by the live request. The arbiter then returns to IDLE.
- Request changes mid-access are ignored; the latched values are used.
- dren and dwen both high: treated as a write; dload = 0.
- Timeout:
  - The wait counter resets on entry to IACC/DACC and increments each cycle without ram_ready.
  - When it reaches TIMEOUT: return to IDLE, set bus_err=1, issue no hit.
  - bus_err clears only on reset.
  - ram_ready in the same cycle as the counter reaching TIMEOUT counts as completion (hit issued, no error).
- Reset mid-access: immediate return to IDLE, RAM enables drop asynchronously, no hit.

Test Plan:
1. Single fetch: iren=1, iaddr=0x100, RAM ready 2 cycles after access start with 0xDEADBEEF. Required: ram_ren=1, ram_addr=0x100 for 3 cycles; then ihit=1 for 1 cycle with iload=0xDEADBEEF; then IDLE.
2. Contention: iren and dwen both asserted (daddr=0x200, dstore=0x55), ram_ready immediate. Required: DACC first with ram_wen=1 and dhit; one IDLE cycle; then IACC and ihit.
3. Starvation: iren held; dren re-asserted after every dhit; STARVE_LIMIT=4. Required: exactly 4 data grants, then a fetch grant (ihit), then data resumes.
4. Timeout: dren=1, ram_ready never asserted, TIMEOUT=255. Required: bus_err rises after 255 DACC cycles; no dhit; IDLE; a following fetch completes normally; bus_err stays 1.
5. Drop and reset: dren dropped during DACC, then ram_ready. Required: no dhit; IDLE next cycle. Separately, nRST low mid-IACC. Required: ram_ren=0 immediately; all outputs at reset values.
